// File: rtl/ftdi_sync_fifo_bridge.sv
// ftdi_sync_fifo_bridge
// Bridges an FT232H-style 245 synchronous FIFO bus to an RX and a TX byte stream.
// Each direction has a small first-word-fall-through FIFO. Read and write visits
// are arbitrated round-robin and capped at a burst length. A turnaround cycle
// separates every change of bus direction, so the FTDI and the FPGA never drive
// the bus in the same cycle.
module ftdi_sync_fifo_bridge #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int RX_BURST = 64,
    parameter int TX_BURST = 64
) (
    input  logic                      clk_60,
    input  logic                      rst_n,
    input  logic [7:0]                ftdi_din,
    output logic [7:0]                ftdi_dout,
    output logic                      ftdi_dout_oe,
    input  logic                      rxf_n,
    input  logic                      txe_n,
    output logic                      oe_n,
    output logic                      rd_n,
    output logic                      wr_n,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic [$clog2(TX_DEPTH):0] tx_level
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_LW = RX_AW + 1;
    localparam int TX_LW = TX_AW + 1;
    localparam int BMAX  = (RX_BURST > TX_BURST) ? RX_BURST : TX_BURST;
    localparam int CW    = $clog2(BMAX) + 1;

    typedef enum logic [2:0] {IDLE, RD_OE, RD, RD_END, WR} state_t;

    state_t          state_reg, state_next;
    logic            last_rx_reg, last_rx_next;     // 1 = most recent visit was a read
    logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;
    logic            oe_n_reg, dout_oe_reg;

    // RX FIFO storage and bookkeeping
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_LW-1:0] rx_level_reg;
    logic             rx_full, rx_empty, rx_push, rx_pop, rx_ok;

    // TX FIFO storage and bookkeeping
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_LW-1:0] tx_level_reg;
    logic             tx_full, tx_empty, tx_push, tx_pop, tx_ok;

    assign rx_full  = (rx_level_reg == RX_LW'(RX_DEPTH));
    assign rx_empty = (rx_level_reg == '0);
    assign tx_full  = (tx_level_reg == TX_LW'(TX_DEPTH));
    assign tx_empty = (tx_level_reg == '0);

    // Strobes are combinational so that a rising rxf_n/txe_n stops the transfer on the same edge
    assign rd_n = !(state_reg == RD) | rxf_n | rx_full;
    assign wr_n = !(state_reg == WR) | txe_n | tx_empty;

    assign rx_push = !rd_n;
    assign rx_pop  = rx_ready & !rx_empty;
    assign tx_push = tx_valid & !tx_full;
    assign tx_pop  = !wr_n;

    assign rx_ok = !rxf_n & !rx_full;
    assign tx_ok = !txe_n & !tx_empty;

    assign oe_n         = oe_n_reg;
    assign ftdi_dout_oe = dout_oe_reg;
    assign ftdi_dout    = tx_mem[tx_rd_ptr_reg];
    assign rx_data      = rx_mem[rx_rd_ptr_reg];
    assign rx_valid     = !rx_empty;
    assign tx_ready     = !tx_full;
    assign rx_level     = rx_level_reg;
    assign tx_level     = tx_level_reg;

    // Next-state logic: arbitration, burst counting and visit exit conditions
    always_comb begin
        state_next     = state_reg;
        last_rx_next   = last_rx_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                burst_cnt_next = '0;
                if (rx_ok && (!last_rx_reg || !tx_ok)) begin
                    state_next = RD_OE;
                end else if (tx_ok) begin
                    state_next = WR;
                end
            end
            RD_OE: begin
                state_next = RD;
            end
            RD: begin
                if (rx_push) begin
                    burst_cnt_next = burst_cnt_reg + CW'(1);
                end
                if (rxf_n || rx_full || (rx_push && (burst_cnt_reg == CW'(RX_BURST - 1)))) begin
                    state_next = RD_END;
                end
            end
            RD_END: begin
                last_rx_next = 1'b1;
                state_next   = IDLE;
            end
            WR: begin
                if (tx_pop) begin
                    burst_cnt_next = burst_cnt_reg + CW'(1);
                end
                if (txe_n || tx_empty || (tx_pop && (burst_cnt_reg == CW'(TX_BURST - 1)))) begin
                    last_rx_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered bus-direction controls derived from the next state
    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_rx_reg   <= 1'b0;
            burst_cnt_reg <= '0;
            oe_n_reg      <= 1'b1;
            dout_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_rx_reg   <= last_rx_next;
            burst_cnt_reg <= burst_cnt_next;
            oe_n_reg      <= !((state_next == RD_OE) || (state_next == RD));
            dout_oe_reg   <= (state_next == WR);
        end
    end

    // RX FIFO data write; storage is not reset, only the pointers are
    always_ff @(posedge clk_60) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= ftdi_din;
        end
    end

    // TX FIFO data write
    always_ff @(posedge clk_60) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= tx_data;
        end
    end

    // RX FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_level_reg  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_AW'(1);
            end
            if (rx_push && !rx_pop) begin
                rx_level_reg <= rx_level_reg + RX_LW'(1);
            end else if (!rx_push && rx_pop) begin
                rx_level_reg <= rx_level_reg - RX_LW'(1);
            end
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_level_reg  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_AW'(1);
            end
            if (tx_push && !tx_pop) begin
                tx_level_reg <= tx_level_reg + TX_LW'(1);
            end else if (!tx_push && tx_pop) begin
                tx_level_reg <= tx_level_reg - TX_LW'(1);
            end
        end
    end

endmodule
